// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback request handshakes and register-file write port shared by
// the pipeline, the mul/div unit and rf_wb_arbiter.
interface rf_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              pipe_valid;
    logic              pipe_ready;
    logic [ADDR_W-1:0] pipe_rt;
    logic [ADDR_W-1:0] pipe_rd;
    logic              pipe_reg_dst;
    logic [DATA_W-1:0] pipe_wdata;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_waddr;
    logic [DATA_W-1:0] md_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              force_active;

    modport master (
        output pipe_valid, pipe_rt, pipe_rd, pipe_reg_dst, pipe_wdata,
        output md_valid, md_waddr, md_wdata,
        input  pipe_ready, md_ready, rf_we, rf_waddr, rf_wdata, force_active
    );

    modport slave (
        input  pipe_valid, pipe_rt, pipe_rd, pipe_reg_dst, pipe_wdata,
        input  md_valid, md_waddr, md_wdata,
        output pipe_ready, md_ready, rf_we, rf_waddr, rf_wdata, force_active
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and
// mul/div results; pipeline has priority, mul/div is forced in after MAX_WAIT denials.
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input logic    clk,
    input logic    rst_n,
    rf_wb_if.slave bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORMAL, FORCE_MD} state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic [CW-1:0]     cnt_inc;
    logic [ADDR_W-1:0] pipe_addr;
    logic              pipe_xfer;
    logic              md_xfer;

    assign pipe_addr        = bus.pipe_reg_dst ? bus.pipe_rd : bus.pipe_rt;
    // Readys are gated by rst_n so nothing is accepted while reset is held.
    assign bus.pipe_ready   = rst_n & ((state == NORMAL) | ~bus.md_valid);
    assign bus.md_ready     = rst_n & ((state == FORCE_MD) | ~bus.pipe_valid);
    assign pipe_xfer        = bus.pipe_valid & bus.pipe_ready;
    assign md_xfer          = bus.md_valid & bus.md_ready;
    assign cnt_inc          = wait_cnt + 1'b1;
    assign bus.force_active = state == FORCE_MD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NORMAL;
            wait_cnt     <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            if (state == FORCE_MD) begin
                state    <= NORMAL;
                wait_cnt <= '0;
            end else if (bus.md_valid & ~bus.md_ready) begin
                state    <= (cnt_inc == CW'(MAX_WAIT)) ? FORCE_MD : NORMAL;
                wait_cnt <= (cnt_inc == CW'(MAX_WAIT)) ? '0 : cnt_inc;
            end else begin
                wait_cnt <= '0;
            end
            // Writes to $zero are accepted but never reach the register file.
            if (pipe_xfer) begin
                bus.rf_we    <= |pipe_addr;
                bus.rf_waddr <= pipe_addr;
                bus.rf_wdata <= bus.pipe_wdata;
            end else if (md_xfer) begin
                bus.rf_we    <= |bus.md_waddr;
                bus.rf_waddr <= bus.md_waddr;
                bus.rf_wdata <= bus.md_wdata;
            end else begin
                bus.rf_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus hand sequences for reset, starvation
// forcing and back-to-back alternation.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    rf_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        dst;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] mdd;
        logic        epr;
        logic        emr;
        logic        efa;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
    } vec_t;

    vec_t v [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] rt, input logic [4:0] rd, input logic dst,
                         input logic [31:0] pd, input logic mv, input logic [4:0] ma, input logic [31:0] mdd);
        bus.pipe_valid   = pv;
        bus.pipe_rt      = rt;
        bus.pipe_rd      = rd;
        bus.pipe_reg_dst = dst;
        bus.pipe_wdata   = pd;
        bus.md_valid     = mv;
        bus.md_waddr     = ma;
        bus.md_wdata     = mdd;
    endtask

    initial begin
        v[0]  = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0,  32'h0};
        v[1]  = '{1, 3, 7, 1, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 0, 1, 7,  32'hDEADBEEF};
        v[2]  = '{1, 3, 7, 0, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 0, 1, 3,  32'hDEADBEEF};
        v[3]  = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h55,   1, 1, 0, 0, 0,  32'h55};
        v[4]  = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0,  32'h55};
        v[5]  = '{0, 0, 0, 0, 32'h0,        1, 12, 32'hA5A5, 1, 1, 0, 1, 12, 32'hA5A5};
        v[6]  = '{1, 0, 9, 0, 32'h77,       0, 0, 32'h0,    1, 0, 0, 0, 0,  32'h77};
        v[7]  = '{1, 0, 11, 1, 32'h1,       1, 9, 32'h1234, 1, 0, 0, 1, 11, 32'h1};
        v[8]  = '{1, 0, 12, 1, 32'h2,       1, 9, 32'h1234, 1, 0, 0, 1, 12, 32'h2};
        v[9]  = '{1, 0, 13, 1, 32'h3,       1, 9, 32'h1234, 1, 0, 0, 1, 13, 32'h3};
        v[10] = '{1, 0, 14, 1, 32'h4,       1, 9, 32'h1234, 1, 0, 0, 1, 14, 32'h4};
        v[11] = '{1, 0, 20, 1, 32'h20,      1, 9, 32'h1234, 0, 1, 1, 1, 9,  32'h1234};
        v[12] = '{1, 0, 21, 1, 32'h21,      0, 0, 32'h0,    1, 0, 0, 1, 21, 32'h21};
        v[13] = '{1, 0, 1, 1, 32'h101,      1, 9, 32'h99,   1, 0, 0, 1, 1,  32'h101};
        v[14] = '{1, 0, 1, 1, 32'h102,      1, 9, 32'h99,   1, 0, 0, 1, 1,  32'h102};
        v[15] = '{1, 0, 1, 1, 32'h103,      1, 9, 32'h99,   1, 0, 0, 1, 1,  32'h103};
        v[16] = '{1, 0, 1, 1, 32'h104,      1, 9, 32'h99,   1, 0, 0, 1, 1,  32'h104};
        v[17] = '{1, 0, 2, 1, 32'h200,      0, 0, 32'h0,    1, 1, 1, 1, 2,  32'h200};
        v[18] = '{1, 0, 3, 1, 32'h300,      1, 9, 32'h99,   1, 0, 0, 1, 3,  32'h300};
        v[19] = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 3,  32'h300};
        v[20] = '{1, 0, 4, 1, 32'h401,      1, 9, 32'h99,   1, 0, 0, 1, 4,  32'h401};
        v[21] = '{1, 0, 4, 1, 32'h402,      1, 9, 32'h99,   1, 0, 0, 1, 4,  32'h402};
        v[22] = '{1, 0, 4, 1, 32'h403,      1, 9, 32'h99,   1, 0, 0, 1, 4,  32'h403};
        v[23] = '{1, 0, 4, 1, 32'h404,      1, 9, 32'h99,   1, 0, 0, 1, 4,  32'h404};
        v[24] = '{1, 0, 5, 1, 32'h500,      1, 9, 32'h99,   0, 1, 1, 1, 9,  32'h99};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset rf_we", 32'(bus.rf_we), 0);
        chk("reset rf_waddr", 32'(bus.rf_waddr), 0);
        chk("reset rf_wdata", bus.rf_wdata, 0);
        chk("reset force_active", 32'(bus.force_active), 0);
        chk("reset pipe_ready", 32'(bus.pipe_ready), 0);
        chk("reset md_ready", 32'(bus.md_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(v[i].pv, v[i].rt, v[i].rd, v[i].dst, v[i].pd, v[i].mv, v[i].ma, v[i].mdd);
            #1;
            chk($sformatf("vec%0d pipe_ready", i), 32'(bus.pipe_ready), 32'(v[i].epr));
            chk($sformatf("vec%0d md_ready", i), 32'(bus.md_ready), 32'(v[i].emr));
            chk($sformatf("vec%0d force_active", i), 32'(bus.force_active), 32'(v[i].efa));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rf_we", i), 32'(bus.rf_we), 32'(v[i].ewe));
            chk($sformatf("vec%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(v[i].ewa));
            chk($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, v[i].ewd);
        end

        // Back-to-back alternating single-cycle requests from each source.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 2 == 0)
                drive(1, 0, 5'(i + 1), 1, 32'hB000 + 32'(i), 0, 0, 0);
            else
                drive(0, 0, 0, 0, 0, 1, 5'(i + 1), 32'hC000 + 32'(i));
            #1;
            chk($sformatf("b2b%0d ready", i), 32'((i % 2 == 0) ? bus.pipe_ready : bus.md_ready), 1);
            chk($sformatf("b2b%0d force_active", i), 32'(bus.force_active), 0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d rf_we", i), 32'(bus.rf_we), 1);
            chk($sformatf("b2b%0d rf_waddr", i), 32'(bus.rf_waddr), i + 1);
            chk($sformatf("b2b%0d rf_wdata", i), bus.rf_wdata, ((i % 2 == 0) ? 32'hB000 : 32'hC000) + 32'(i));
            chk($sformatf("b2b%0d wait_cnt", i), 32'(dut.wait_cnt), 0);
        end

        // Reset asserted just before the edge of a pending pipeline write to r5.
        @(negedge clk);
        drive(1, 0, 5, 1, 32'hCAFE, 0, 0, 0);
        #4;
        rst_n = 1'b0;
        #3;
        chk("midrst rf_we", 32'(bus.rf_we), 0);
        chk("midrst rf_waddr", 32'(bus.rf_waddr), 0);
        chk("midrst pipe_ready", 32'(bus.pipe_ready), 0);
        chk("midrst md_ready", 32'(bus.md_ready), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst rf_we", 32'(bus.rf_we), 0);
        chk("postrst rf_waddr", 32'(bus.rf_waddr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
